pk_decode: RTL and testbench
============================

// Module: pk_decode
// PURPOSE
// - Inverse of public-key encoding (FIPS 204 Alg 23, pkDecode). Reads a packed ML-DSA pk
//   (rho || SimpleBitPack(t1), 10 bits/coeff) from a 64-bit-word RAM.
// - Emits rho as 4 words and t1 as K*N/4 groups of 4 zero-extended 24-bit coefficients.
// - Sits in front of Verify: feeds rho to ExpandA and t1 to the w'_approx datapath.
// PARAMETERS
// K                 8     number of t1 polynomials
// N                 256   coefficients per polynomial
// D                 13    dropped bits; COEFF_PACK_LENGTH = 23 - D = 10
// WORD_WIDTH        64    pk RAM word width
// COEFF_WIDTH       24    output coefficient width (Z_q)
// COEFF_PER_WORD    4     coefficients per output group
// RHO_WORDS         4     rho words (256 / WORD_WIDTH)
// ADDR_PACK_WIDTH   15    pk RAM address width
// PK_BASE_OFFSET    0     word address of pk[0] in RAM
// PORTS
// clk         in   1    clock, rising edge
// rst_n       in   1    asynchronous active-low reset
// start       in   1    1-cycle pulse; sampled only in IDLE
// re_pk       out  1    pk RAM read enable
// addr_pk     out  15   pk RAM word address
// dout_pk     in   64   pk RAM read data, valid exactly 1 cycle after re_pk
// rho_valid   out  1    rho_out valid this cycle (no backpressure)
// rho_idx     out  2    rho word index 0..3
// rho_out     out  64   rho word, byte 0 in bits [7:0]
// t_valid     out  1    t_coeff group valid
// t_ready     in   1    consumer accepts group when t_valid && t_ready
// t_idx       out  9    group index 0..511 (poly = t_idx[8:6], coeff base = 4*t_idx[5:0])
// t_coeff     out  96   group; [24*i +: 24] = {14'b0, coeff 4*t_idx+i}
// busy        out  1    high from cycle after start until done
// done        out  1    1-cycle pulse after final group handshake
// BEHAVIOUR
// - Reset (async, any time incl. mid-operation): state IDLE; all outputs 0; buffer, counters,
//   and pending-read flag cleared. No RAM read completes after reset release.
// - FSM: IDLE -start-> RHO_RD -4 reads issued-> T1_UNPACK -512th handshake-> DONE -> IDLE.
//   start in any state other than IDLE is ignored.
// - RHO_RD: re_pk high 4 consecutive cycles; addr = PK_BASE_OFFSET + 0..3.
//   Read issued in cycle c -> rho_out/rho_valid/rho_idx registered, visible in cycle c+2.
// - T1_UNPACK: 104-bit LSB-first bit buffer; 7-bit fill count (0..103).
//   - Read issue: re_pk when fill < 40 and no read pending. Max 1 outstanding read.
//   - Addr: PK_BASE_OFFSET + 4 + w, w = 0..319 (320 t1 words total).
//   - Append: returning word placed at buffer bit [fill], fill += 64.
// - Group: t_valid is registered; asserted when fill >= 40 and the output register is empty
//   (or being emptied this cycle).
//   - coeff i = buffer[10*i +: 10].
//   - On load: buffer >>= 40, fill -= 40.
//   - Append and consume in the same cycle: fill += 24; shifted buffer receives word at [fill-40].
// - Backpressure: t_valid, t_coeff, and t_idx hold stable until t_ready. A fresh group may load
//   in the same cycle as a handshake (full throughput is not required; no bubble-free guarantee).
// - Bit accounting: 320*64 = 512*40, so the buffer is exactly empty after the last group.
//   No read is issued past word 323.
// - done: asserted the cycle after the 512th handshake, for 1 cycle. busy drops in the same cycle.
// - Coefficients are 10-bit unsigned (0..1023). Upper 14 bits are always zero.
//   No range check is needed; every 10-bit value is legal.
// TESTING
// - Reset: drive rst_n=0 mid-T1_UNPACK -> all outputs 0 immediately;
//   a new start after release decodes from word 0.
// - Rho: RAM words 0..3 = 64'h1111..11, 64'h2222..22, 64'h3333..33, 64'h4444..44; pulse start.
//   -> re_pk cycles 1..4; rho_valid cycles 3..6 with idx 0..3 and matching data.
// - Simple group: t1 word0 = 64'h0000_0001_0030_0801, t_ready=1.
//   -> group 0 t_coeff = {24'd4, 24'd3, 24'd2, 24'd1}.
// - Word straddle: word0 = 64'hFFFF_FF00_0000_0000, word1 = 0.
//   -> group 1 coeffs = {0, 0x00F, 0x3FF, 0x3FF} (i = 3..0).
// - Full pk all-ones, random t_ready (30% high).
//   -> 512 groups, all coeffs 0x0003FF, t_idx 0..511 in order.
//   -> Data stable while stalled; exactly 324 reads; done once; start during busy ignored.
// - Round trip: random t1 (10-bit) and rho -> pkEncode -> RAM -> pk_decode.
//   -> Outputs equal the originals, bit-exact, for 20 seeds.

Source files
------------

// File: rtl/pk_decode.sv
// Unpacks an ML-DSA public key (rho || 10-bit packed t1) read from a 64-bit word RAM.
// rho leaves as four words; t1 leaves as groups of four zero-extended coefficients.
module pk_decode #(
  parameter int K               = 8,
  parameter int N               = 256,
  parameter int D               = 13,
  parameter int WORD_WIDTH      = 64,
  parameter int COEFF_WIDTH     = 24,
  parameter int COEFF_PER_WORD  = 4,
  parameter int RHO_WORDS       = 4,
  parameter int ADDR_PACK_WIDTH = 15,
  parameter int PK_BASE_OFFSET  = 0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  output logic                                  re_pk,
  output logic [ADDR_PACK_WIDTH-1:0]            addr_pk,
  input  logic [WORD_WIDTH-1:0]                 dout_pk,
  output logic                                  rho_valid,
  output logic [$clog2(RHO_WORDS)-1:0]          rho_idx,
  output logic [WORD_WIDTH-1:0]                 rho_out,
  output logic                                  t_valid,
  input  logic                                  t_ready,
  output logic [$clog2(K*N/COEFF_PER_WORD)-1:0] t_idx,
  output logic [COEFF_WIDTH*COEFF_PER_WORD-1:0] t_coeff,
  output logic                                  busy,
  output logic                                  done,
  output logic [1:0]                            state_dbg
);
  localparam int PACK_LEN  = 23 - D;
  localparam int GRP_BITS  = PACK_LEN * COEFF_PER_WORD;
  localparam int BUF_W     = GRP_BITS + WORD_WIDTH;
  localparam int T1_WORDS  = K * N * PACK_LEN / WORD_WIDTH;
  localparam int N_GROUPS  = K * N / COEFF_PER_WORD;
  localparam int TOT_WORDS = RHO_WORDS + T1_WORDS;
  localparam int CNT_W     = $clog2(TOT_WORDS + 1);
  localparam int IDX_W     = $clog2(N_GROUPS);
  localparam int RIDX_W    = $clog2(RHO_WORDS);
  localparam int FILL_W    = $clog2(BUF_W);
  localparam int TC_W      = COEFF_WIDTH * COEFF_PER_WORD;

  typedef enum logic [1:0] {S_IDLE, S_RHO, S_T1, S_DONE} state_t;

  // Handshake: a group transfers on any rising edge where t_valid && t_ready;
  // t_valid, t_idx and t_coeff are held unchanged until that edge.
  state_t                state_q, state_d;
  logic [CNT_W-1:0]      rd_cnt_q, rd_cnt_d;
  logic                  rd_vld_q, rd_t1_q;
  logic [RIDX_W-1:0]     rd_idx_q;
  logic [BUF_W-1:0]      buf_q, buf_d, buf_base;
  logic [FILL_W-1:0]     fill_q, fill_d, fill_base;
  logic [IDX_W-1:0]      grp_cnt_q, grp_cnt_d;
  logic                  t_valid_q, t_valid_d;
  logic [IDX_W-1:0]      t_idx_q, t_idx_d;
  logic [TC_W-1:0]       t_coeff_q, t_coeff_d;
  logic                  rho_valid_q;
  logic [RIDX_W-1:0]     rho_idx_q;
  logic [WORD_WIDTH-1:0] rho_out_q;
  logic                  go, t_hs, load, append;

  assign go     = (state_q == S_IDLE) && start;
  assign t_hs   = t_valid_q && t_ready;
  assign load   = (state_q == S_T1) && (fill_q >= FILL_W'(GRP_BITS)) && (!t_valid_q || t_ready);
  assign append = rd_vld_q && rd_t1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RHO;
      S_RHO:   if (rd_cnt_q == CNT_W'(RHO_WORDS - 1)) state_d = S_T1;
      S_T1:    if (t_hs && (t_idx_q == IDX_W'(N_GROUPS - 1))) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // One outstanding read at most: the returning word is folded in before the next issue.
  always_comb begin
    re_pk = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      S_RHO: begin
        re_pk = 1'b1;
        busy  = 1'b1;
      end
      S_T1: begin
        re_pk = !rd_vld_q && (fill_q < FILL_W'(GRP_BITS)) && (rd_cnt_q < CNT_W'(TOT_WORDS));
        busy  = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    buf_base  = load ? (buf_q >> GRP_BITS) : buf_q;
    fill_base = load ? (fill_q - FILL_W'(GRP_BITS)) : fill_q;
    buf_d     = buf_base;
    fill_d    = fill_base;
    if (append) begin
      buf_d  = buf_base | (BUF_W'(dout_pk) << fill_base);
      fill_d = fill_base + FILL_W'(WORD_WIDTH);
    end
    rd_cnt_d  = rd_cnt_q + CNT_W'(re_pk);
    grp_cnt_d = grp_cnt_q;
    t_valid_d = t_valid_q;
    t_idx_d   = t_idx_q;
    t_coeff_d = t_coeff_q;
    if (load) begin
      t_valid_d = 1'b1;
      t_idx_d   = grp_cnt_q;
      grp_cnt_d = grp_cnt_q + IDX_W'(1);
      for (int i = 0; i < COEFF_PER_WORD; i++)
        t_coeff_d[COEFF_WIDTH*i +: COEFF_WIDTH] = COEFF_WIDTH'(buf_q[PACK_LEN*i +: PACK_LEN]);
    end else if (t_hs) begin
      t_valid_d = 1'b0;
    end
    if (go) begin
      rd_cnt_d  = '0;
      grp_cnt_d = '0;
      buf_d     = '0;
      fill_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q    <= '0;
      rd_vld_q    <= 1'b0;
      rd_t1_q     <= 1'b0;
      rd_idx_q    <= '0;
      buf_q       <= '0;
      fill_q      <= '0;
      grp_cnt_q   <= '0;
      t_valid_q   <= 1'b0;
      t_idx_q     <= '0;
      t_coeff_q   <= '0;
      rho_valid_q <= 1'b0;
      rho_idx_q   <= '0;
      rho_out_q   <= '0;
    end else begin
      rd_cnt_q    <= rd_cnt_d;
      rd_vld_q    <= re_pk;
      rd_t1_q     <= (state_q == S_T1);
      rd_idx_q    <= rd_cnt_q[RIDX_W-1:0];
      buf_q       <= buf_d;
      fill_q      <= fill_d;
      grp_cnt_q   <= grp_cnt_d;
      t_valid_q   <= t_valid_d;
      t_idx_q     <= t_idx_d;
      t_coeff_q   <= t_coeff_d;
      rho_valid_q <= rd_vld_q && !rd_t1_q;
      if (rd_vld_q && !rd_t1_q) begin
        rho_idx_q <= rd_idx_q;
        rho_out_q <= dout_pk;
      end
    end
  end

  assign addr_pk   = ADDR_PACK_WIDTH'(PK_BASE_OFFSET) + ADDR_PACK_WIDTH'(rd_cnt_q);
  assign rho_valid = rho_valid_q;
  assign rho_idx   = rho_idx_q;
  assign rho_out   = rho_out_q;
  assign t_valid   = t_valid_q;
  assign t_idx     = t_idx_q;
  assign t_coeff   = t_coeff_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_pk_decode.sv
// Bench for pk_decode: RAM model, table vectors, all-ones/backpressure run,
// asynchronous reset mid-decode and randomised encode/decode round trips.
module tb_pk_decode;
  localparam int TOT = 324;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        t_ready = 1'b0;
  logic        re_pk;
  logic [14:0] addr_pk;
  logic [63:0] dout_pk = '0;
  logic        rho_valid;
  logic [1:0]  rho_idx;
  logic [63:0] rho_out;
  logic        t_valid;
  logic [8:0]  t_idx;
  logic [95:0] t_coeff;
  logic        busy;
  logic        done;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  pk_decode dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .re_pk(re_pk), .addr_pk(addr_pk), .dout_pk(dout_pk),
    .rho_valid(rho_valid), .rho_idx(rho_idx), .rho_out(rho_out),
    .t_valid(t_valid), .t_ready(t_ready), .t_idx(t_idx), .t_coeff(t_coeff),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  logic [63:0] mem [0:TOT-1];
  always @(posedge clk)
    if (re_pk) dout_pk <= (int'(addr_pk) < TOT) ? mem[int'(addr_pk)] : 64'hDEAD_BEEF_DEAD_BEEF;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [9:0]  exp_c [0:2047];
  logic [104:0] exp_q [$];
  logic [65:0]  rho_q [$];

  typedef struct {
    logic [63:0] w0;
    logic [63:0] w1;
    int          grp;
    logic [95:0] exp;
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // t1 stream bit p lives in word 4 + p/64, bit p%64.
  task automatic derive_exp();
    for (int j = 0; j < 2048; j++)
      for (int b = 0; b < 10; b++) begin
        int p = 10 * j + b;
        exp_c[j][b] = mem[4 + p / 64][p % 64];
      end
  endtask

  task automatic pack_exp();
    for (int j = 0; j < 2048; j++)
      for (int b = 0; b < 10; b++) begin
        int p = 10 * j + b;
        mem[4 + p / 64][p % 64] = exp_c[j][b];
      end
  endtask

  task automatic push_expect();
    logic [95:0] g;
    exp_q.delete();
    rho_q.delete();
    for (int i = 0; i < 4; i++) rho_q.push_back({2'(i), mem[i]});
    for (int j = 0; j < 512; j++) begin
      for (int i = 0; i < 4; i++) g[24*i +: 24] = {14'b0, exp_c[4*j+i]};
      exp_q.push_back({9'(j), g});
    end
  endtask

  task automatic run_decode(input int ready_pct, input int inj_cyc, input int tbl_grp,
                            input logic [95:0] tbl_exp);
    int           reads, dones;
    logic         stalled, got_done, hs;
    logic [104:0] held, e;
    logic [65:0]  r;
    reads = 0; dones = 0; stalled = 1'b0; got_done = 1'b0; held = '0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      if (cyc <= 5) chk("re_pk_timing", re_pk, (cyc >= 1 && cyc <= 4));
      if (cyc <= 7) chk("rho_valid_timing", rho_valid, (cyc >= 3 && cyc <= 6));
      if (cyc <= 1) chk("busy_start", busy, (cyc == 1));
      if (rho_valid) begin
        if (rho_q.size() == 0) chk("rho_extra", 1, 0);
        else begin
          r = rho_q.pop_front();
          chk("rho_word", {rho_idx, rho_out}, r);
        end
      end
      if (re_pk) begin
        chk("read_addr", addr_pk, reads);
        reads++;
      end
      if (stalled) chk("stall_hold", {t_valid, t_idx, t_coeff}, {1'b1, held});
      if (done) begin
        dones++;
        got_done = 1'b1;
        chk("busy_at_done", busy, 0);
        break;
      end
      start   = (cyc == 0) || (cyc == inj_cyc);
      t_ready = ($urandom_range(0, 99) < ready_pct);
      hs      = t_valid && t_ready;
      stalled = t_valid && !t_ready;
      held    = {t_idx, t_coeff};
      if (hs) begin
        if (exp_q.size() == 0) chk("group_extra", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("group", {t_idx, t_coeff}, e);
          if (int'(t_idx) == tbl_grp) chk("table_group", t_coeff, tbl_exp);
        end
      end
    end
    start = 1'b0;
    t_ready = 1'b0;
    chk("timeout", got_done, 1);
    chk("read_count", reads, TOT);
    chk("groups_left", exp_q.size(), 0);
    chk("rho_left", rho_q.size(), 0);
    repeat (5) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("done_once", dones, 1);
    chk("idle_tvalid", t_valid, 0);
  endtask

  initial begin
    tbl[0] = '{64'h0000_0001_0030_0801, 64'h0, 0, {24'd4, 24'd3, 24'd2, 24'd1}};
    tbl[1] = '{64'hFFFF_FF00_0000_0000, 64'h0, 1, {24'h0, 24'h00F, 24'h3FF, 24'h3FF}};
    tbl[2] = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1, {24'h3FF, 24'h3F0, 24'h0, 24'h0}};
    tbl[3] = '{64'h0123_4567_89AB_CDEF, 64'h0, 0, {24'h19E, 24'h09A, 24'h2F3, 24'h1EF}};

    // clock/reset
    repeat (3) @(negedge clk);
    chk("rst_re_pk", re_pk, 0);
    chk("rst_t_valid", t_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rho_valid", rho_valid, 0);
    chk("rst_t_coeff", t_coeff, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // rho timing plus table vectors; start pulsed again during the rho reads
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < TOT; i++) mem[i] = '0;
      mem[0] = {16{4'h1}};
      mem[1] = {16{4'h2}};
      mem[2] = {16{4'h3}};
      mem[3] = {16{4'h4}};
      mem[4] = tbl[v].w0;
      mem[5] = tbl[v].w1;
      derive_exp();
      push_expect();
      run_decode(100, 2, tbl[v].grp, tbl[v].exp);
    end

    // all-ones key under 30% ready, start pulsed mid-unpack
    for (int i = 0; i < TOT; i++) mem[i] = '1;
    for (int j = 0; j < 2048; j++) exp_c[j] = 10'h3FF;
    push_expect();
    run_decode(30, 300, -1, '0);

    // asynchronous reset in the middle of T1 unpacking
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t_ready = 1'b1;
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_re_pk", re_pk, 0);
    chk("arst_addr", addr_pk, 0);
    chk("arst_rho_valid", rho_valid, 0);
    chk("arst_rho_out", {rho_idx, rho_out}, 0);
    chk("arst_t_valid", t_valid, 0);
    chk("arst_t_group", {t_idx, t_coeff}, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    t_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_expect();
    run_decode(50, -1, -1, '0);

    // encode random rho/t1 into RAM and decode it back
    for (int s = 0; s < 20; s++) begin
      for (int i = 0; i < 4; i++) mem[i] = {$urandom(), $urandom()};
      for (int j = 0; j < 2048; j++) exp_c[j] = 10'($urandom_range(0, 1023));
      pack_exp();
      push_expect();
      run_decode(70, -1, -1, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
